// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl
// Multi-cycle control unit for the accumulator-style core. Each instruction
// moves through fetch, execute, memory and write-back. Instruction and data
// memories are handshaked with ack inputs. Retired instructions are counted.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   start_i        begin execution (honoured only in IDLE or HALT)
//   imem_ack_i     mach_code_i holds a valid instruction this cycle
//   mach_code_i    instruction word
//   dmem_ack_i     data-memory access complete
//   zero_i         ALU zero flag, used for the branch decision
//   imem_req_o     instruction fetch request
//   pc_en_o        one-cycle PC update pulse, coincides with retire
//   pc_sel_o       with pc_en_o: 1 = load jump target, 0 = PC+1
//   jptr_o         jump-pointer LUT index
//   aluop_o        ALU operation
//   ra_o/rb_o/wd_o reg-file A, B and write addresses
//   wen_r_o        register write enable
//   wen_d_o        data-memory write enable
//   ldr_o, str_o   load / store strobes
//   busy_o         executing (FETCH/EXEC/MEM/WB)
//   done_o         halted
//   retired_o      saturating retired-instruction count
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset; waits for start
// FETCH | requests instruction; captures it into IR on imem_ack
// EXEC  | ALU/branch retire here; load/store go on to MEM
// MEM   | load/store strobes held until dmem_ack
// WB    | load write-back and retire
// HALT  | HALT executed; done asserted; start restarts
module multi_cycle_ctrl #(
    parameter int IW = 9,
    parameter int RW = 2,
    parameter int AW = 3,
    parameter int JW = 2,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          imem_ack_i,
    input  logic [IW-1:0] mach_code_i,
    input  logic          dmem_ack_i,
    input  logic          zero_i,
    output logic          imem_req_o,
    output logic          pc_en_o,
    output logic          pc_sel_o,
    output logic [JW-1:0] jptr_o,
    output logic [AW-1:0] aluop_o,
    output logic [RW-1:0] ra_o,
    output logic [RW-1:0] rb_o,
    output logic [RW-1:0] wd_o,
    output logic          wen_r_o,
    output logic          wen_d_o,
    output logic          ldr_o,
    output logic          str_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [CW-1:0] retired_o
);

    localparam int FW = IW - 2 - RW;

    localparam logic [1:0] CLS_ALU = 2'b00;
    localparam logic [1:0] CLS_LD  = 2'b01;
    localparam logic [1:0] CLS_ST  = 2'b10;
    localparam logic [1:0] CLS_BR  = 2'b11;

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        WB    = 3'd4,
        HALT  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ir_q, ir_d;
    logic [CW-1:0] retired_q, retired_d;
    logic          retire;
    logic          cnt_clr;

    logic [1:0]    cls;
    logic [RW-1:0] ra_f;
    logic [FW-1:0] f_f;
    logic          is_halt;
    logic          in_instr;

    assign cls      = ir_q[IW-1:IW-2];
    assign ra_f     = ir_q[IW-3 -: RW];
    assign f_f      = ir_q[FW-1:0];
    assign is_halt  = (cls == CLS_BR) && (&f_f);
    assign in_instr = (state_q == EXEC) || (state_q == MEM) || (state_q == WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        retire     = 1'b0;
        cnt_clr    = 1'b0;
        imem_req_o = 1'b0;
        pc_en_o    = 1'b0;
        pc_sel_o   = 1'b0;
        jptr_o     = '0;
        aluop_o    = '0;
        ra_o       = '0;
        rb_o       = '0;
        wd_o       = '0;
        wen_r_o    = 1'b0;
        wen_d_o    = 1'b0;
        ldr_o      = 1'b0;
        str_o      = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;

        // Register fields are presented for the whole life of the
        // instruction; fields a class does not use stay at zero.
        if (in_instr) begin
            case (cls)
                CLS_ALU: begin
                    aluop_o = f_f[AW-1:0];
                    ra_o    = ra_f;
                    rb_o    = f_f[AW +: RW];
                    wd_o    = ra_f;
                end
                CLS_LD: begin
                    rb_o = f_f[RW-1:0];
                    wd_o = ra_f;
                end
                CLS_ST: begin
                    ra_o = ra_f;
                    rb_o = f_f[RW-1:0];
                end
                default: begin
                    if (!is_halt) begin
                        jptr_o = f_f[JW-1:0];
                    end
                end
            endcase
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = FETCH;
                    cnt_clr = 1'b1;
                end
            end
            FETCH: begin
                imem_req_o = 1'b1;
                busy_o     = 1'b1;
                if (imem_ack_i) begin
                    ir_d    = mach_code_i;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                busy_o = 1'b1;
                case (cls)
                    CLS_ALU: begin
                        wen_r_o = 1'b1;
                        pc_en_o = 1'b1;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                    CLS_LD, CLS_ST: begin
                        state_d = MEM;
                    end
                    default: begin
                        if (is_halt) begin
                            state_d = HALT;
                        end else begin
                            pc_en_o  = 1'b1;
                            pc_sel_o = zero_i;
                            retire   = 1'b1;
                            state_d  = FETCH;
                        end
                    end
                endcase
            end
            MEM: begin
                busy_o = 1'b1;
                if (cls == CLS_LD) begin
                    ldr_o = 1'b1;
                    if (dmem_ack_i) begin
                        state_d = WB;
                    end
                end else begin
                    str_o   = 1'b1;
                    wen_d_o = 1'b1;
                    if (dmem_ack_i) begin
                        pc_en_o = 1'b1;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            WB: begin
                busy_o  = 1'b1;
                wen_r_o = 1'b1;
                ldr_o   = 1'b1;
                pc_en_o = 1'b1;
                retire  = 1'b1;
                state_d = FETCH;
            end
            HALT: begin
                done_o = 1'b1;
                if (start_i) begin
                    state_d = FETCH;
                    cnt_clr = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Saturating count: a retire at full scale still pulses pc_en, count holds.
    always_comb begin
        retired_d = retired_q;
        if (cnt_clr) begin
            retired_d = '0;
        end else if (retire && (retired_q != {CW{1'b1}})) begin
            retired_d = retired_q + CNT_ONE;
        end
    end

    assign retired_o = retired_q;

endmodule
